beat_player_ctrl: RTL and testbench

//  Transport controller for the step sequencer: produces the beat index (ibeatNum) and play enable (en)
//  the sequencer decodes into tones and LEDs. Divides clk to the beat rate and runs a play/pause/stop FSM

---
 rtl/beat_player_ctrl.sv | 157 +++++++++++++++
 tb/tb_beat_player_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_player_ctrl.sv
// rtl/beat_player_ctrl.sv - beat-rate transport FSM (idle/play/pause/tail), optional TEMPO_ADJ_EN tempo control
module beat_player_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = 8,
  parameter int LEN     = 64,
  parameter int TAIL    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_pulse,
  input  logic        stop_pulse,
  input  logic        loop_en,
`ifdef TEMPO_ADJ_EN
  input  logic        tempo_up,
  input  logic        tempo_dn,
  output logic [1:0]  tempo,
`endif
  output logic [11:0] ibeatNum,
  output logic        en,
  output logic        beat_tick,
  output logic        done,
  output logic [1:0]  state
);

  localparam int DIV = CLK_HZ / BEAT_HZ;
  localparam int DW  = $clog2(DIV + 1);
  localparam int TW  = (TAIL < 2) ? 1 : $clog2(TAIL + 1);

  localparam logic [DW-1:0] DIV_V     = DW'(DIV);
  localparam logic [11:0]   LEN_V     = 12'(LEN);
  localparam logic [11:0]   LAST_V    = 12'(LEN - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_TAIL  = 2'b11
  } state_t;

  state_t        st;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] period;
  logic [TW-1:0] tail_cnt;
  logic          wrap;

  assign state = st;

  // Divider reaches the end of the current beat period while the transport is running
  always_comb begin
    wrap = 1'b0;
    if ((st == S_PLAY) || (st == S_TAIL))
      wrap = (div_cnt == (period - 1'b1));
  end

`ifdef TEMPO_ADJ_EN
  // Tempo register saturates at both ends; period only reloads at a beat boundary or while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tempo  <= 2'd0;
      period <= DIV_V;
    end else begin
      if (tempo_up && !tempo_dn && (tempo != 2'd3))
        tempo <= tempo + 2'd1;
      else if (tempo_dn && !tempo_up && (tempo != 2'd0))
        tempo <= tempo - 2'd1;
      if (wrap || (st == S_IDLE))
        period <= DIV_V >> tempo;
    end
  end
`else
  assign period = DIV_V;
`endif

  // Transport FSM: stop beats everything, pause freezes beat and divider, tail parks at LEN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      ibeatNum  <= 12'd0;
      en        <= 1'b0;
      beat_tick <= 1'b0;
      done      <= 1'b0;
      div_cnt   <= '0;
      tail_cnt  <= '0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;
      if (stop_pulse) begin
        st       <= S_IDLE;
        ibeatNum <= 12'd0;
        en       <= 1'b0;
        div_cnt  <= '0;
        tail_cnt <= '0;
      end else begin
        case (st)
          S_IDLE: begin
            ibeatNum <= 12'd0;
            en       <= 1'b0;
            div_cnt  <= '0;
            tail_cnt <= '0;
            if (play_pulse) begin
              st <= S_PLAY;
              en <= 1'b1;
            end
          end
          S_PLAY: begin
            if (play_pulse) begin
              st <= S_PAUSE;
              en <= 1'b0;
            end else if (wrap) begin
              div_cnt   <= '0;
              beat_tick <= 1'b1;
              if (ibeatNum < LAST_V) begin
                ibeatNum <= ibeatNum + 12'd1;
              end else if (loop_en) begin
                ibeatNum <= 12'd0;
              end else begin
                ibeatNum <= LEN_V;
                st       <= S_TAIL;
                tail_cnt <= '0;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          S_PAUSE: begin
            if (play_pulse) begin
              st <= S_PLAY;
              en <= 1'b1;
            end
          end
          S_TAIL: begin
            if (wrap) begin
              div_cnt   <= '0;
              beat_tick <= 1'b1;
              if (tail_cnt == TAIL_LAST) begin
                st       <= S_IDLE;
                ibeatNum <= 12'd0;
                en       <= 1'b0;
                done     <= 1'b1;
                tail_cnt <= '0;
              end else begin
                tail_cnt <= tail_cnt + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beat_player_ctrl.sv
// tb/tb_beat_player_ctrl.sv - scoreboard bench for beat_player_ctrl (DIV=10, LEN=4, TAIL=2)
module tb_beat_player_ctrl;

  logic        clk;
  logic        rst;
  logic        play_pulse;
  logic        stop_pulse;
  logic        loop_en;
  logic [11:0] ibeatNum;
  logic        en;
  logic        beat_tick;
  logic        done;
  logic [1:0]  state;
`ifdef TEMPO_ADJ_EN
  logic        tempo_up;
  logic        tempo_dn;
  logic [1:0]  tempo;
`endif

  beat_player_ctrl #(
    .CLK_HZ (40),
    .BEAT_HZ(4),
    .LEN    (4),
    .TAIL   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .play_pulse(play_pulse),
    .stop_pulse(stop_pulse),
    .loop_en   (loop_en),
`ifdef TEMPO_ADJ_EN
    .tempo_up  (tempo_up),
    .tempo_dn  (tempo_dn),
    .tempo     (tempo),
`endif
    .ibeatNum  (ibeatNum),
    .en        (en),
    .beat_tick (beat_tick),
    .done      (done),
    .state     (state)
  );

  typedef struct {
    int cyc;
    int ib;
    int st;
    int en;
    int dn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", nm, act, expv, edge_n);
    end
  endfunction

  function automatic void push(input int c, input int ib, input int st, input int e, input int d);
    exp_t x;
    x.cyc = c; x.ib = ib; x.st = st; x.en = e; x.dn = d;
    exp_q.push_back(x);
  endfunction

  // Monitor: every beat_tick/done presentation must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && (beat_tick || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_edge", edge_n, e.cyc);
        chk("evt_ibeat", int'(ibeatNum), e.ib);
        chk("evt_state", int'(state), e.st);
        chk("evt_en", int'(en), e.en);
        chk("evt_done", int'(done), e.dn);
      end
    end
  end

  // which: 0 play, 1 stop, 2 play+stop, 3 tempo_up, 4 tempo_dn, 5 up+dn
  task automatic pulse_at(input int which, input int tgt);
    while (edge_n < tgt - 1) begin
      @(posedge clk); #1;
    end
    case (which)
      0: play_pulse = 1'b1;
      1: stop_pulse = 1'b1;
      2: begin play_pulse = 1'b1; stop_pulse = 1'b1; end
`ifdef TEMPO_ADJ_EN
      3: tempo_up = 1'b1;
      4: tempo_dn = 1'b1;
      5: begin tempo_up = 1'b1; tempo_dn = 1'b1; end
`endif
      default: ;
    endcase
    @(posedge clk); #1;
    play_pulse = 1'b0;
    stop_pulse = 1'b0;
`ifdef TEMPO_ADJ_EN
    tempo_up = 1'b0;
    tempo_dn = 1'b0;
`endif
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int errs;
    rst = 1'b1;
    play_pulse = 1'b0;
    stop_pulse = 1'b0;
    loop_en = 1'b0;
`ifdef TEMPO_ADJ_EN
    tempo_up = 1'b0;
    tempo_dn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_ibeat", int'(ibeatNum), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_tick", int'(beat_tick), 0);
    chk("rst_done", int'(done), 0);

    // Single pass, loop off: three steps, tail of two beats, done pulse
    t0 = edge_n + 2;
    push(t0 + 10, 1, 1, 1, 0);
    push(t0 + 20, 2, 1, 1, 0);
    push(t0 + 30, 3, 1, 1, 0);
    push(t0 + 40, 4, 3, 1, 0);
    push(t0 + 50, 4, 3, 1, 0);
    push(t0 + 60, 0, 0, 0, 1);
    pulse_at(0, t0);
    @(negedge clk);
    chk("start_en", int'(en), 1);
    chk("start_state", int'(state), 1);
    chk("start_ibeat", int'(ibeatNum), 0);
    drain(100);
    @(negedge clk);
    chk("end_state", int'(state), 0);
    chk("end_en", int'(en), 0);

    // Looping: three full loops stay in PLAY without done, then stop
    loop_en = 1'b1;
    t0 = edge_n + 2;
    for (int i = 1; i <= 12; i++) push(t0 + 10 * i, i % 4, 1, 1, 0);
    pulse_at(0, t0);
    drain(200);
    pulse_at(1, edge_n + 2);
    @(negedge clk);
    chk("loop_stop_state", int'(state), 0);
    chk("loop_stop_ibeat", int'(ibeatNum), 0);
    loop_en = 1'b0;

    // Pause at divider=5 during beat 2, hold 50 cycles, resume finishes beat in 5 cycles
    t0 = edge_n + 2;
    push(t0 + 10, 1, 1, 1, 0);
    push(t0 + 20, 2, 1, 1, 0);
    pulse_at(0, t0);
    drain(50);
    pulse_at(0, t0 + 26);
    @(negedge clk);
    chk("pause_state", int'(state), 2);
    chk("pause_en", int'(en), 0);
    errs = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      if (ibeatNum != 12'd2 || en != 1'b0 || state != 2'd2) errs++;
    end
    chk("pause_hold_errs", errs, 0);
    push(t0 + 81, 3, 1, 1, 0);
    push(t0 + 91, 4, 3, 1, 0);
    push(t0 + 101, 4, 3, 1, 0);
    push(t0 + 111, 0, 0, 0, 1);
    pulse_at(0, t0 + 76);
    drain(100);

    // Stop together with play and a tick: stop wins, no event
    t0 = edge_n + 2;
    push(t0 + 10, 1, 1, 1, 0);
    pulse_at(0, t0);
    drain(50);
    pulse_at(2, t0 + 20);
    @(negedge clk);
    chk("stop_prio_state", int'(state), 0);
    chk("stop_prio_ibeat", int'(ibeatNum), 0);
    chk("stop_prio_done", int'(done), 0);
    chk("stop_prio_en", int'(en), 0);

    // Asynchronous reset while in TAIL
    t0 = edge_n + 2;
    push(t0 + 10, 1, 1, 1, 0);
    push(t0 + 20, 2, 1, 1, 0);
    push(t0 + 30, 3, 1, 1, 0);
    push(t0 + 40, 4, 3, 1, 0);
    pulse_at(0, t0);
    drain(100);
    while (edge_n < t0 + 43) @(negedge clk);
    chk("pre_rst_state", int'(state), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_ibeat", int'(ibeatNum), 0);
    chk("async_rst_en", int'(en), 0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef TEMPO_ADJ_EN
    // Tempo change mid-beat takes effect only after the current beat wraps
    t0 = edge_n + 2;
    push(t0 + 10, 1, 1, 1, 0);
    push(t0 + 12, 2, 1, 1, 0);
    push(t0 + 14, 3, 1, 1, 0);
    push(t0 + 16, 4, 3, 1, 0);
    push(t0 + 18, 4, 3, 1, 0);
    push(t0 + 20, 0, 0, 0, 1);
    pulse_at(0, t0);
    pulse_at(3, t0 + 2);
    pulse_at(3, t0 + 3);
    pulse_at(3, t0 + 4);
    pulse_at(4, t0 + 5);
    @(negedge clk);
    chk("tempo_after_adj", int'(tempo), 2);
    drain(60);
    for (int i = 0; i < 5; i++) pulse_at(4, edge_n + 1);
    @(negedge clk);
    chk("tempo_floor", int'(tempo), 0);
    pulse_at(3, edge_n + 1);
    pulse_at(5, edge_n + 1);
    @(negedge clk);
    chk("tempo_both", int'(tempo), 1);
`endif

    repeat (30) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
